// File: rtl/vga_text_console.sv
// Character-cell text console: byte stream in, {attr,char} cells out via a registered
// read port. Scrolls by rotating a top-row pointer and blanking the recycled row.
module vga_text_console #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ATTR_W = 4,
  parameter int unsigned CW     = $clog2(COLS),
  parameter int unsigned RW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_char,
  input  logic [ATTR_W-1:0] in_attr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     rd_col,
  input  logic [RW-1:0]     rd_row,
  output logic [8+ATTR_W-1:0] rd_data,
  output logic [CW-1:0]     cursor_col,
  output logic [RW-1:0]     cursor_row,
  output logic              busy
);

  localparam int unsigned DW    = 8 + ATTR_W;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned IW    = RW + CW + 1;

  localparam logic [DW-1:0] BLANK = DW'(8'h20);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLR_ROW = 2'd1;
  localparam logic [1:0] S_CLR_ALL = 2'd2;

  logic [DW-1:0] mem [0:CELLS-1];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] top_q, top_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] clr_last_q, clr_last_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          newline;
  logic [IW-1:0] cur_phys;
  logic [IW-1:0] rd_phys;
  logic          rd_in_range;

  // Logical row -> physical row, done wide so the sum never truncates before the mod.
  function automatic logic [IW-1:0] phys_row(input logic [RW-1:0] row, input logic [RW-1:0] top);
    logic [IW-1:0] sum;
    sum = IW'(row) + IW'(top);
    if (sum >= IW'(ROWS)) sum = sum - IW'(ROWS);
    return sum;
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [IW-1:0] prow, input logic [CW-1:0] col);
    return AW'(prow * IW'(COLS) + IW'(col));
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    we         = 1'b0;
    newline    = 1'b0;
    cur_phys   = phys_row(row_q, top_q);
    waddr      = cell_addr(cur_phys, col_q);
    wdata      = BLANK;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we    = 1'b1;
            wdata = {in_attr, in_char};
            if (col_q < CW'(COLS - 1)) begin
              col_d = col_q + CW'(1);
            end else begin
              col_d   = '0;
              newline = 1'b1;
            end
          end else begin
            case (in_char)
              8'h0D: col_d = '0;
              8'h0A: begin
                col_d   = '0;
                newline = 1'b1;
              end
              8'h08: begin
                if (col_q != '0) begin
                  col_d = col_q - CW'(1);
                  we    = 1'b1;
                  waddr = cell_addr(cur_phys, col_q - CW'(1));
                end
              end
              8'h0C: begin
                col_d      = '0;
                row_d      = '0;
                top_d      = '0;
                clr_addr_d = '0;
                clr_last_d = AW'(CELLS - 1);
                state_d    = S_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      S_CLR_ROW, S_CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_addr_q;
        if (clr_addr_q == clr_last_q) begin
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        clr_addr_d = '0;
        clr_last_d = AW'(CELLS - 1);
        state_d    = S_CLR_ALL;
      end
    endcase

    // At the bottom line the old top row is recycled as the new, blanked bottom line.
    if (newline) begin
      if (row_q < RW'(ROWS - 1)) begin
        row_d = row_q + RW'(1);
      end else begin
        top_d      = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
        clr_addr_d = cell_addr(IW'(top_q), '0);
        clr_last_d = cell_addr(IW'(top_q), CW'(COLS - 1));
        state_d    = S_CLR_ROW;
      end
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_comb begin
    rd_phys     = phys_row(rd_row, top_q);
    rd_in_range = (IW'(rd_col) < IW'(COLS)) && (IW'(rd_row) < IW'(ROWS));
    rd_data_d   = rd_in_range ? mem[cell_addr(rd_phys, rd_col)] : BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLR_ALL;
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      clr_addr_q <= '0;
      clr_last_q <= AW'(CELLS - 1);
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Cell storage; the read above samples before this write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign rd_data    = rd_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
